dma_cmd_queue: RTL and testbench

DMA_CMD_QUEUE -- requirements
Module: dma_cmd_queue

---
 rtl/dma_cmd_queue_if.sv | 27 ++
 rtl/dma_cmd_queue.sv | 100 ++++++++++
 tb/tb_dma_cmd_queue.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/dma_cmd_queue_if.sv
// dma_cmd_queue_if: core-to-queue command handshake and queue-to-channel issue bus
interface dma_cmd_queue_if #(
   parameter int XLEN   = 32,
   parameter int NUM_CH = 4,
   parameter int SIZE_W = 13,
   localparam int CH_W  = NUM_CH > 1 ? $clog2(NUM_CH) : 1
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [2:0]        cmd_funct3;
   logic [CH_W-1:0]   cmd_ch;
   logic [SIZE_W-1:0] cmd_size;
   logic [XLEN-1:0]   cmd_addr;
   logic [NUM_CH-1:0] dma_en;
   logic [2:0]        dma_funct3;
   logic [SIZE_W-1:0] dma_size;
   logic [XLEN-1:0]   dma_mem_addr;
   logic [NUM_CH-1:0] dma_busy;
   modport master (
      output cmd_valid, cmd_funct3, cmd_ch, cmd_size, cmd_addr, dma_busy,
      input  cmd_ready, dma_en, dma_funct3, dma_size, dma_mem_addr
   );
   modport slave (
      input  cmd_valid, cmd_funct3, cmd_ch, cmd_size, cmd_addr, dma_busy,
      output cmd_ready, dma_en, dma_funct3, dma_size, dma_mem_addr
   );
endinterface

// File: rtl/dma_cmd_queue.sv
// dma_cmd_queue: in-order DMA command FIFO issuing one-hot single-cycle strobes
// to per-channel engines, holding back a channel until its busy is visible.
module dma_cmd_queue #(
   parameter int XLEN   = 32,
   parameter int DEPTH  = 4,
   parameter int NUM_CH = 4,
   parameter int SIZE_W = 13
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   dma_cmd_queue_if.slave             io_bus,
   input  logic                       i_flush,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic                       o_full,
   output logic                       o_empty,
   output logic                       o_idle,
   output logic                       o_err
);
   localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
   localparam int NB   = 2 ** CH_W;
   localparam int AW   = $clog2(DEPTH);
   localparam int CW   = $clog2(DEPTH + 1);
   typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_ISSUE} state_t;
   state_t            r_state, w_next;
   logic [2:0]        r_f3   [DEPTH];
   logic [CH_W-1:0]   r_ch   [DEPTH];
   logic [SIZE_W-1:0] r_size [DEPTH];
   logic [XLEN-1:0]   r_addr [DEPTH];
   logic [AW-1:0]     r_wr, r_rd;
   logic [CW-1:0]     r_cnt;
   logic [NUM_CH-1:0] r_en;
   logic [2:0]        r_of3;
   logic [SIZE_W-1:0] r_osize;
   logic [XLEN-1:0]   r_oaddr;
   logic              r_err;
   logic [NB-1:0]     w_blk;
   logic              w_push, w_ch_ok, w_store, w_issue;
   assign o_count             = r_cnt;
   assign o_full              = r_cnt == CW'(DEPTH);
   assign o_empty             = r_cnt == '0;
   assign o_err               = r_err;
   assign o_idle              = o_empty && r_en == '0 && io_bus.dma_busy == '0;
   assign io_bus.cmd_ready    = i_rst_n && !o_full && !i_flush;
   assign io_bus.dma_en       = r_en;
   assign io_bus.dma_funct3   = r_of3;
   assign io_bus.dma_size     = r_osize;
   assign io_bus.dma_mem_addr = r_oaddr;
   assign w_push  = io_bus.cmd_valid && io_bus.cmd_ready;
   assign w_ch_ok = 32'(io_bus.cmd_ch) < NUM_CH;
   assign w_store = w_push && w_ch_ok;
   // The strobe register doubles as the guard: it covers the one cycle before busy rises.
   assign w_blk   = NB'(io_bus.dma_busy | r_en);
   always_comb begin
      w_issue = r_state != S_EMPTY && !o_empty && !i_flush && !w_blk[r_ch[r_rd]];
      w_next  = i_flush ? S_EMPTY : w_issue ? S_ISSUE
              : (o_empty && !w_store) ? S_EMPTY : S_WAIT;
      if (!i_flush && !w_issue && r_state == S_ISSUE && r_cnt == '0 && !w_store) w_next = S_EMPTY;
      if (!i_flush && !w_issue && r_state == S_EMPTY && w_store) w_next = S_WAIT;
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_EMPTY;
         r_wr    <= '0;
         r_rd    <= '0;
         r_cnt   <= '0;
         r_en    <= '0;
         r_of3   <= '0;
         r_osize <= '0;
         r_oaddr <= '0;
         r_err   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            r_f3[i]   <= '0;
            r_ch[i]   <= '0;
            r_size[i] <= '0;
            r_addr[i] <= '0;
         end
      end else begin
         r_state <= w_next;
         r_err   <= r_err | (w_push && !w_ch_ok);
         r_en    <= w_issue ? NUM_CH'(1) << r_ch[r_rd] : '0;
         r_of3   <= w_issue ? r_f3[r_rd] : '0;
         r_osize <= w_issue ? r_size[r_rd] : '0;
         r_oaddr <= w_issue ? r_addr[r_rd] : '0;
         if (w_store) begin
            r_f3[r_wr]   <= io_bus.cmd_funct3;
            r_ch[r_wr]   <= io_bus.cmd_ch;
            r_size[r_wr] <= io_bus.cmd_size;
            r_addr[r_wr] <= io_bus.cmd_addr;
         end
         if (i_flush) begin
            r_cnt <= '0;
            r_rd  <= r_wr;
         end else begin
            r_wr  <= r_wr + AW'(w_store);
            r_rd  <= r_rd + AW'(w_issue);
            r_cnt <= r_cnt + CW'(w_store) - CW'(w_issue);
         end
      end
   end
endmodule

// File: tb/tb_dma_cmd_queue.sv
// tb_dma_cmd_queue: directed and random stimulus against a queue-based reference
// model; a second 3-channel instance exercises the bad-channel error flag.
module tb_dma_cmd_queue;
   localparam int DEPTH  = 4;
   localparam int NUM_CH = 4;
   typedef struct {
      logic [2:0]  f3;
      int          ch;
      logic [12:0] sz;
      logic [31:0] ad;
   } cmd_t;
   logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, flush3 = 1'b0;
   logic [2:0] count, count3;
   logic full, empty, idle, err, full3, empty3, idle3, err3;
   int vectors = 0, miscompares = 0;
   logic        d_v = 0, d_fl = 0;
   logic [2:0]  d_f3 = 0;
   logic [1:0]  d_ch = 0;
   logic [12:0] d_sz = 0;
   logic [31:0] d_ad = 0;
   logic [3:0]  d_busy = 0;
   cmd_t q[$];
   cmd_t m_out;
   int   m_en_ch = -1;
   bit   m_err = 0;
   int   last_issue = -100, cyc = 0;
   dma_cmd_queue_if #(.NUM_CH(NUM_CH)) bus ();
   dma_cmd_queue_if #(.NUM_CH(3)) b3 ();
   dma_cmd_queue #(.DEPTH(DEPTH), .NUM_CH(NUM_CH)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .io_bus(bus), .i_flush(flush),
      .o_count(count), .o_full(full), .o_empty(empty), .o_idle(idle), .o_err(err));
   dma_cmd_queue #(.DEPTH(DEPTH), .NUM_CH(3)) u_dut3 (
      .i_clk(clk), .i_rst_n(rst_n), .io_bus(b3), .i_flush(flush3),
      .o_count(count3), .o_full(full3), .o_empty(empty3), .o_idle(idle3), .o_err(err3));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic model_reset();
      q.delete();
      m_en_ch = -1;
      m_err = 0;
   endtask
   // One clock: drive, check ready before the edge, advance the model, check after the edge.
   task automatic tick();
      bit rdy, iss;
      bus.cmd_valid = d_v; bus.cmd_funct3 = d_f3; bus.cmd_ch = d_ch;
      bus.cmd_size = d_sz; bus.cmd_addr = d_ad; bus.dma_busy = d_busy; flush = d_fl;
      #1;
      rdy = q.size() < DEPTH && !d_fl;
      chk("ready", bus.cmd_ready, rdy);
      iss = !d_fl && q.size() > 0 && !d_busy[q[0].ch] && m_en_ch != q[0].ch;
      if (iss) begin
         m_out = q.pop_front();
         m_en_ch = m_out.ch;
      end else m_en_ch = -1;
      if (d_fl) q.delete();
      if (d_v && rdy) begin
         if (int'(d_ch) < NUM_CH) q.push_back('{d_f3, int'(d_ch), d_sz, d_ad});
         else m_err = 1;
      end
      @(posedge clk); #1;
      cyc++;
      chk("dma_en", bus.dma_en, m_en_ch < 0 ? 0 : 64'(1) << m_en_ch);
      chk("dma_funct3", bus.dma_funct3, m_en_ch < 0 ? 0 : m_out.f3);
      chk("dma_size", bus.dma_size, m_en_ch < 0 ? 0 : m_out.sz);
      chk("dma_addr", bus.dma_mem_addr, m_en_ch < 0 ? 0 : m_out.ad);
      chk("count", count, q.size());
      chk("full", full, q.size() == DEPTH);
      chk("empty", empty, q.size() == 0);
      chk("err", err, m_err);
      chk("idle", idle, q.size() == 0 && m_en_ch < 0 && d_busy == 0);
      if (bus.dma_en[0]) begin
         chk("ch0_spacing_ok", cyc - last_issue >= 2, 1'b1);
         last_issue = cyc;
      end
      @(negedge clk);
   endtask
   task automatic push(input logic [1:0] ch, input logic [2:0] f3, input logic [12:0] sz, input logic [31:0] ad);
      d_v = 1; d_ch = ch; d_f3 = f3; d_sz = sz; d_ad = ad;
      tick();
      d_v = 0;
   endtask
   initial begin
      bus.cmd_valid = 0; bus.cmd_funct3 = 0; bus.cmd_ch = 0; bus.cmd_size = 0;
      bus.cmd_addr = 0; bus.dma_busy = 0;
      b3.cmd_valid = 0; b3.cmd_funct3 = 0; b3.cmd_ch = 0; b3.cmd_size = 0;
      b3.cmd_addr = 0; b3.dma_busy = 0;
      @(posedge clk); #1;
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_en", bus.dma_en, 0);
      chk("rst_idle", idle, 1);
      chk("rst_err", err, 0);
      chk("rst_ready_low", bus.cmd_ready, 0);
      @(negedge clk);
      rst_n = 1;
      // Single command: strobe one cycle after the push edge.
      push(2'd2, 3'd1, 13'h40, 32'h2000_0000);
      chk("req038_count1", count, 1);
      chk("req038_no_bypass", bus.dma_en, 0);
      tick();
      chk("req038_en", bus.dma_en, 4'b0100);
      chk("req038_addr", bus.dma_mem_addr, 32'h2000_0000);
      tick();
      // Fill behind a busy channel, fifth push stalls.
      d_busy = 4'b0001;
      for (int i = 0; i < 5; i++) push(2'd0, 3'(i), 13'(i + 1), 32'h1000 * i);
      chk("req039_full", full, 1);
      d_busy = 0;
      for (int i = 0; i < 10; i++) tick();
      // Four channels back to back.
      for (int i = 0; i < 4; i++) push(2'(i), 3'd2, 13'(8 * i), 32'hA000 + i);
      for (int i = 0; i < 3; i++) tick();
      // Blocked head holds back an idle channel behind it.
      d_busy = 4'b0010;
      push(2'd1, 3'd3, 13'd5, 32'hB000);
      push(2'd3, 3'd4, 13'd6, 32'hB100);
      for (int i = 0; i < 3; i++) tick();
      chk("req041_held", count, 2);
      d_busy = 0;
      for (int i = 0; i < 4; i++) tick();
      // Flush beats a same-cycle push and issue.
      d_busy = 4'b1111;
      for (int i = 0; i < 3; i++) push(2'(i), 3'd5, 13'd1, 32'hC000 + i);
      d_busy = 0; d_fl = 1;
      push(2'd3, 3'd6, 13'd2, 32'hC100);
      d_fl = 0;
      chk("req042_count", count, 0);
      chk("req042_idle", idle, 1);
      tick();
      // Randomised traffic.
      for (int i = 0; i < 400; i++) begin
         d_v = 1'($urandom_range(0, 1));
         d_ch = 2'($urandom);
         d_f3 = 3'($urandom);
         d_sz = 13'($urandom);
         d_ad = $urandom;
         d_fl = $urandom_range(0, 19) == 0;
         d_busy = {4{1'b0}};
         for (int b = 0; b < 4; b++) d_busy[b] = $urandom_range(0, 3) == 0;
         tick();
      end
      d_v = 0; d_fl = 0; d_busy = 0;
      for (int i = 0; i < 8; i++) tick();
      // Out-of-range channel on the 3-channel instance.
      b3.cmd_valid = 1; b3.cmd_ch = 2'd3;
      tick();
      chk("req043_err", err3, 1);
      chk("req043_count", count3, 0);
      b3.cmd_ch = 2'd1; b3.dma_busy = 3'b111;
      tick();
      b3.cmd_valid = 0;
      chk("req043_count_ok", count3, 1);
      chk("req043_err_sticky", err3, 1);
      // Asynchronous reset with a strobe in flight and entries queued.
      push(2'd0, 3'd1, 13'd3, 32'hD000);
      push(2'd1, 3'd1, 13'd3, 32'hD100);
      push(2'd2, 3'd1, 13'd3, 32'hD200);
      chk("pre_rst_strobe", bus.dma_en != 0, 1'b1);
      #2 rst_n = 0;
      #1;
      chk("arst_en", bus.dma_en, 0);
      chk("arst_addr", bus.dma_mem_addr, 0);
      chk("arst_count", count, 0);
      chk("arst_empty", empty, 1);
      chk("arst_idle", idle, 1);
      chk("arst_err3", err3, 0);
      chk("arst_count3", count3, 0);
      chk("arst_ready", bus.cmd_ready, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1;
      tick();
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
